// File: rtl/bus_master_bridge.sv
// Byte-stream bus initiator: decodes host command bytes, runs one bus
// transaction per command with a GNT timeout, and returns status/read data.
module bus_master_bridge #(
  parameter int unsigned TIMEOUT  = 256,
  parameter int unsigned CE_WIDTH = 8
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic [7:0]          i_RX_DATA,
  input  logic                i_RX_VALID,
  output logic                o_RX_READY,
  output logic [7:0]          o_TX_DATA,
  output logic                o_TX_VALID,
  input  logic                i_TX_READY,
  output logic [31:0]         o_BUS_ADDR,
  output logic [31:0]         o_BUS_WDATA,
  output logic                o_BUS_WE,
  output logic                o_BUS_RE,
  output logic [1:0]          o_BUS_HB,
  output logic                o_BUS_REQ,
  output logic [CE_WIDTH-1:0] o_BUS_CE,
  input  logic                i_BUS_GNT,
  input  logic [31:0]         i_BUS_RDATA,
  output logic                o_BUSY
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_TMO    = 8'h01;
  localparam logic [7:0] ST_BADOP  = 8'h02;
  localparam logic [7:0] ST_UNMAP  = 8'h03;

  typedef enum logic [2:0] {
    S_OP,
    S_ADDR,
    S_WDATA,
    S_DEC,
    S_BUS,
    S_STAT,
    S_RDATA
  } state_t;

  state_t              state_q, state_d;
  logic                live_q, live_d;
  logic                is_wr_q, is_wr_d;
  logic [1:0]          hb_q, hb_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [7:0]          status_q, status_d;
  logic [CE_WIDTH-1:0] ce_q, ce_d;
  logic [TW-1:0]       tmo_q, tmo_d;

  logic in_bus;
  logic rx_acc;
  logic tx_acc;
  logic op_legal;

  // Output decode; bus outputs are gated by S_BUS so they read 0 elsewhere.
  // live_q keeps RX_READY low while reset is held even though state is S_OP.
  always_comb begin
    in_bus      = (state_q == S_BUS);
    o_RX_READY  = live_q && (state_q == S_OP || state_q == S_ADDR || state_q == S_WDATA);
    o_TX_VALID  = (state_q == S_STAT) || (state_q == S_RDATA);
    o_TX_DATA   = '0;
    if (state_q == S_STAT)       o_TX_DATA = status_q;
    else if (state_q == S_RDATA) o_TX_DATA = rdata_q[7:0];
    o_BUS_REQ   = in_bus;
    o_BUS_ADDR  = in_bus ? addr_q  : '0;
    o_BUS_WDATA = in_bus ? wdata_q : '0;
    o_BUS_HB    = in_bus ? hb_q    : '0;
    o_BUS_CE    = in_bus ? ce_q    : '0;
    o_BUS_WE    = in_bus &&  is_wr_q;
    o_BUS_RE    = in_bus && !is_wr_q;
    o_BUSY      = (state_q != S_OP);
    rx_acc      = o_RX_READY && i_RX_VALID;
    tx_acc      = o_TX_VALID && i_TX_READY;
    op_legal    = (i_RX_DATA[7:4] == 4'h1 || i_RX_DATA[7:4] == 4'h2) &&
                  (i_RX_DATA[3:2] == 2'b00) && (i_RX_DATA[1:0] != 2'b11);
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    live_d   = 1'b1;
    is_wr_d  = is_wr_q;
    hb_d     = hb_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    ce_d     = ce_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_OP: begin
        if (rx_acc) begin
          if (op_legal) begin
            is_wr_d = (i_RX_DATA[7:4] == 4'h1);
            hb_d    = i_RX_DATA[1:0];
            cnt_d   = '0;
            state_d = S_ADDR;
          end else begin
            status_d = ST_BADOP;
            state_d  = S_STAT;
          end
        end
      end
      S_ADDR: begin
        if (rx_acc) begin
          // LSB-first bytes shift in from the top, landing in place after 4.
          addr_d = {i_RX_DATA, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = is_wr_q ? S_WDATA : S_DEC;
        end
      end
      S_WDATA: begin
        if (rx_acc) begin
          wdata_d = {i_RX_DATA, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_DEC;
        end
      end
      S_DEC: begin
        if (32'(addr_q[31:28]) >= CE_WIDTH) begin
          status_d = ST_UNMAP;
          state_d  = S_STAT;
        end else begin
          ce_d    = CE_WIDTH'(1) << addr_q[31:28];
          tmo_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (i_BUS_GNT) begin
          if (!is_wr_q) rdata_d = i_BUS_RDATA;
          status_d = ST_OK;
          state_d  = S_STAT;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          status_d = ST_TMO;
          state_d  = S_STAT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_STAT: begin
        if (tx_acc) begin
          if (!is_wr_q && status_q == ST_OK) begin
            cnt_d   = '0;
            state_d = S_RDATA;
          end else begin
            state_d = S_OP;
          end
        end
      end
      S_RDATA: begin
        if (tx_acc) begin
          rdata_d = {8'h00, rdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_OP;
        end
      end
      default: state_d = S_OP;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q  <= S_OP;
      live_q   <= 1'b0;
      is_wr_q  <= 1'b0;
      hb_q     <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= '0;
      ce_q     <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      live_q   <= live_d;
      is_wr_q  <= is_wr_d;
      hb_q     <= hb_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      ce_q     <= ce_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_bus_master_bridge.sv
// Scoreboard bench for bus_master_bridge: expected bus transactions and TX
// bytes are queued when a command is issued and checked as the DUT emits them.
module tb_bus_master_bridge;

  localparam int unsigned TMO = 8;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b0;
  logic [7:0]  i_RX_DATA = '0;
  logic        i_RX_VALID = 1'b0;
  logic        o_RX_READY;
  logic [7:0]  o_TX_DATA;
  logic        o_TX_VALID;
  logic        i_TX_READY = 1'b0;
  logic [31:0] o_BUS_ADDR;
  logic [31:0] o_BUS_WDATA;
  logic        o_BUS_WE;
  logic        o_BUS_RE;
  logic [1:0]  o_BUS_HB;
  logic        o_BUS_REQ;
  logic [7:0]  o_BUS_CE;
  logic        i_BUS_GNT = 1'b0;
  logic [31:0] i_BUS_RDATA = '0;
  logic        o_BUSY;

  bus_master_bridge #(.TIMEOUT(TMO), .CE_WIDTH(8)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_RX_DATA(i_RX_DATA), .i_RX_VALID(i_RX_VALID), .o_RX_READY(o_RX_READY),
    .o_TX_DATA(o_TX_DATA), .o_TX_VALID(o_TX_VALID), .i_TX_READY(i_TX_READY),
    .o_BUS_ADDR(o_BUS_ADDR), .o_BUS_WDATA(o_BUS_WDATA), .o_BUS_WE(o_BUS_WE),
    .o_BUS_RE(o_BUS_RE), .o_BUS_HB(o_BUS_HB), .o_BUS_REQ(o_BUS_REQ),
    .o_BUS_CE(o_BUS_CE), .i_BUS_GNT(i_BUS_GNT), .i_BUS_RDATA(i_BUS_RDATA),
    .o_BUSY(o_BUSY)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic [1:0]  hb;
    logic [7:0]  ce;
    logic [7:0]  gnt_at;   // REQ cycle (1-based) that gets GNT; 0 = never
    logic [7:0]  cycles;   // expected number of REQ-high cycles
  } txn_t;

  txn_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] outs();
    return {o_RX_READY, o_TX_VALID, o_TX_DATA, o_BUS_ADDR, o_BUS_WDATA, o_BUS_WE,
            o_BUS_RE, o_BUS_HB, o_BUS_REQ, o_BUS_CE, o_BUSY};
  endfunction

  function automatic bit legal_op(input logic [7:0] op);
    return (op[7:4] == 4'h1 || op[7:4] == 4'h2) && op[3:2] == 2'b00 && op[1:0] != 2'b11;
  endfunction

  // Bus responder: checks every REQ cycle against the expected transaction,
  // grants on the scheduled cycle, and checks REQ length when it drops.
  txn_t cur = '0;
  int   req_cnt = 0;
  bit   active = 0;
  bit   abort = 0;
  bit   stray = 0;
  always @(negedge i_CLK) begin
    if (o_BUS_REQ) begin
      if (!active) begin
        active  = 1;
        req_cnt = 0;
        if (exp_bus.size() == 0) begin
          check("unexpected_req", 1, 0);
          cur = '0;
        end else begin
          cur = exp_bus.pop_front();
        end
      end
      req_cnt++;
      check("bus_addr", o_BUS_ADDR, cur.addr);
      if (cur.we) check("bus_wdata", o_BUS_WDATA, cur.wdata);
      check("bus_ce", o_BUS_CE, cur.ce);
      check("bus_hb", o_BUS_HB, cur.hb);
      check("bus_we_re", {o_BUS_WE, o_BUS_RE}, cur.we ? 2'b10 : 2'b01);
      check("busy_in_bus", o_BUSY, 1);
      if (req_cnt == int'(cur.gnt_at)) begin
        i_BUS_GNT   = 1'b1;
        i_BUS_RDATA = cur.rdata;
      end else begin
        i_BUS_GNT   = 1'b0;
        i_BUS_RDATA = $urandom;
      end
    end else begin
      if (active) begin
        active = 0;
        if (abort) abort = 0;
        else check("req_cycles", req_cnt, cur.cycles);
      end
      check("bus_idle", {o_BUS_ADDR, o_BUS_WDATA, o_BUS_WE, o_BUS_RE, o_BUS_HB, o_BUS_CE}, 0);
      i_BUS_GNT   = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      i_BUS_RDATA = $urandom;
    end
  end

  // TX sink: drives READY (with optional stall/random), pops expected bytes
  // on each handshake and checks data stability while stalled.
  int         tx_stall = 0;
  int         tx_count = 0;
  int         stall_at = -1;
  bit         tx_rand = 0;
  bit         held = 0;
  logic [7:0] held_data = '0;
  always @(negedge i_CLK) begin
    logic rdy;
    check("rdy_vld_excl", o_RX_READY & o_TX_VALID, 0);
    if (held) begin
      check("tx_valid_held", o_TX_VALID, 1);
      check("tx_stable", o_TX_DATA, held_data);
    end
    if (tx_count == stall_at && o_TX_VALID) begin
      tx_stall = 5;
      stall_at = -1;
    end
    if (tx_stall > 0) begin
      rdy = 1'b0;
      tx_stall--;
    end else begin
      rdy = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    i_TX_READY = rdy;
    held = 0;
    if (o_TX_VALID) begin
      if (rdy) begin
        tx_count++;
        if (exp_tx.size() == 0) check("tx_unexpected", o_TX_DATA, 9'h100);
        else check("tx_data", o_TX_DATA, exp_tx.pop_front());
      end else begin
        held      = 1;
        held_data = o_TX_DATA;
      end
    end
  end

  bit rx_rand = 0;

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (rx_rand) begin
      repeat ($urandom_range(0, 2)) begin
        i_RX_VALID = 1'b0;
        @(negedge i_CLK);
      end
    end
    i_RX_DATA  = b;
    i_RX_VALID = 1'b1;
    while (!o_RX_READY && n < 200) begin
      @(negedge i_CLK);
      n++;
    end
    if (n >= 200) check("rx_ready_timeout", 0, 1);
    @(negedge i_CLK);
    i_RX_VALID = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(op);
    if (legal_op(op)) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (op[7:4] == 4'h1)
        for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
    end
  endtask

  task automatic expect_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int gnt_at);
    txn_t t;
    bit   ok;
    if (!legal_op(op)) begin
      exp_tx.push_back(8'h02);
    end else if (addr[31:28] >= 4'd8) begin
      exp_tx.push_back(8'h03);
    end else begin
      ok       = (gnt_at >= 1 && gnt_at <= int'(TMO));
      t.addr   = addr;
      t.wdata  = wdata;
      t.rdata  = rdata;
      t.we     = (op[7:4] == 4'h1);
      t.hb     = op[1:0];
      t.ce     = 8'd1 << addr[31:28];
      t.gnt_at = 8'(gnt_at);
      t.cycles = ok ? 8'(gnt_at) : 8'(TMO);
      exp_bus.push_back(t);
      exp_tx.push_back(ok ? 8'h00 : 8'h01);
      if (ok && !t.we)
        for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || o_BUSY) && n < 1000) begin
      @(negedge i_CLK);
      n++;
    end
    check("drain_timeout", n < 1000, 1);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gnt_at);
    expect_cmd(op, addr, wdata, rdata, gnt_at);
    do_cmd(op, addr, wdata);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    txn_t t;
    #1 i_RST = 1'b1;
    repeat (3) @(negedge i_CLK);
    check("reset_outputs", outs(), 0);
    i_RST = 1'b0;
    @(negedge i_CLK);
    @(negedge i_CLK);
    check("idle_rx_ready", o_RX_READY, 1);
    check("idle_busy", o_BUSY, 0);

    // Write then read back, grant on third REQ cycle.
    run_cmd(8'h12, 32'h1000_0000, 32'hDEAD_BEEF, 32'h0, 3);
    run_cmd(8'h22, 32'h1000_0000, 32'h0, 32'hDEAD_BEEF, 3);
    // Immediate grant, byte size, CE 0x01.
    run_cmd(8'h20, 32'h0000_0004, 32'h0, 32'h0000_00A5, 1);
    // Timeout on a read: status 0x01 only, then a good write.
    run_cmd(8'h21, 32'h5000_0000, 32'h0, 32'h0000_1234, 0);
    run_cmd(8'h11, 32'h7000_0002, 32'hCAFE_F00D, 32'h0, 2);
    // GNT arrives in the same cycle the counter reaches TIMEOUT-1.
    run_cmd(8'h22, 32'h0000_0100, 32'h0, 32'h55AA_1234, int'(TMO));

    // Error responses with stray GNT pulses that must be ignored.
    stray = 1;
    run_cmd(8'h33, 32'h0, 32'h0, 32'h0, 0);
    run_cmd(8'h13, 32'h0, 32'h0, 32'h0, 0);
    run_cmd(8'h16, 32'h0, 32'h0, 32'h0, 0);
    run_cmd(8'h22, 32'h9000_0000, 32'h0, 32'h0, 1);
    run_cmd(8'h21, 32'h8000_0000, 32'h0, 32'h0, 1);
    stray = 0;

    // Backpressure: random RX gaps, 5-cycle TX stall during read data.
    rx_rand  = 1;
    stall_at = tx_count + 2;
    run_cmd(8'h22, 32'h3000_0008, 32'h0, 32'h1122_3344, 2);
    tx_rand = 1;
    run_cmd(8'h22, 32'h6000_0000, 32'h0, 32'h8899_AABB, 4);
    run_cmd(8'h12, 32'h6000_0000, 32'h0BAD_F00D, 32'h0, 1);
    tx_rand = 0;
    rx_rand = 0;

    // Reset in the middle of a bus transaction.
    t.addr = 32'h2000_0000; t.wdata = 32'h0102_0304; t.rdata = 32'h0; t.we = 1'b1;
    t.hb = 2'b10; t.ce = 8'h04; t.gnt_at = 8'd0; t.cycles = 8'(TMO);
    exp_bus.push_back(t);
    do_cmd(8'h12, 32'h2000_0000, 32'h0102_0304);
    n = 0;
    while (!o_BUS_REQ && n < 50) begin
      @(negedge i_CLK);
      n++;
    end
    check("req_before_reset", o_BUS_REQ, 1);
    @(negedge i_CLK);
    #2;
    abort = 1;
    i_RST = 1'b1;
    #1;
    check("reset_async_outputs", outs(), 0);
    repeat (2) @(negedge i_CLK);
    check("reset_held_outputs", outs(), 0);
    i_RST = 1'b0;
    @(negedge i_CLK);
    run_cmd(8'h12, 32'h2000_0000, 32'h0A0B_0C0D, 32'h0, 2);

    repeat (5) @(negedge i_CLK);
    check("exp_bus_empty", exp_bus.size(), 0);
    check("exp_tx_empty", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_master_bridge.md
Name: bus_master_bridge

Overview:
- Byte-stream-driven bus initiator. It lets an external host issue reads and writes on the system bus, through the same initiator/responder protocol the core uses.
- It sits between a byte source/sink (UART RX/TX byte interfaces or a test harness) and the system bus arbitration point.
- It decodes commands, drives one bus transaction per command, and returns a status byte plus read data.
- It includes a GNT timeout so a missing responder cannot hang the bridge.

Parameters:
- TIMEOUT, 256: cycles to wait for i_BUS_GNT after REQ is raised before aborting; must be ≥2.
- CE_WIDTH, 8: number of one-hot chip-enable lines.

Ports:
- i_CLK  in  1  system clock, rising edge
- i_RST  in  1  asynchronous, active-high reset
- i_RX_DATA  in  8  command byte from host
- i_RX_VALID  in  1  i_RX_DATA valid
- o_RX_READY  out  1  bridge accepts byte; transfer occurs when VALID&READY
- o_TX_DATA  out  8  response byte to host
- o_TX_VALID  out  1  o_TX_DATA valid
- i_TX_READY  in  1  host accepts byte; transfer occurs when VALID&READY
- o_BUS_ADDR  out  32  transaction address
- o_BUS_WDATA  out  32  write data
- o_BUS_WE  out  1  write strobe
- o_BUS_RE  out  1  read strobe
- o_BUS_HB  out  2  size: 00 byte, 01 half, 10 word
- o_BUS_REQ  out  1  transaction request
- o_BUS_CE  out  CE_WIDTH  one-hot chip enable
- i_BUS_GNT  in  1  responder completion
- i_BUS_RDATA  in  32  read data, sampled in the GNT cycle
- o_BUSY  out  1  high in every state except S_OP

Behaviour:
Reset:
- Applies immediately, mid-transaction included.
- All outputs go to 0; state goes to S_OP; internal registers are cleared.
- REQ drops without waiting for GNT.

Command format (bytes, little-endian):
- Opcode byte: [7:4] command, 1 = write, 2 = read. [3:2] must be 00. [1:0] = HB; 11 is illegal.
- Then 4 address bytes, LSB first.
- Write only: 4 data bytes, LSB first.

Response format:
- Status byte: 0x00 ok, 0x01 timeout, 0x02 bad opcode, 0x03 unmapped address.
- After a read with ok status only: 4 data bytes, LSB first.

State machine:
- S_OP: o_RX_READY = 1. On byte accept:
  - Opcode legal: latch command and HB, go to S_ADDR.
  - Opcode illegal: load status 0x02, go to S_STAT. No further bytes are consumed.
- S_ADDR: o_RX_READY = 1. Accept 4 bytes via a 2-bit counter.
  - After byte 3: write goes to S_WDATA, read goes to S_DEC.
- S_WDATA: o_RX_READY = 1. Accept 4 bytes, then go to S_DEC.
- S_DEC: one cycle.
  - If ADDR[31:28] ≥ CE_WIDTH: status 0x03, go to S_STAT, no bus activity.
  - Else: register CE = 1<<ADDR[31:28], go to S_BUS.
- S_BUS: REQ, CE, ADDR, WDATA, HB and WE/RE are driven from registers and held stable until exit.
  - WE = write, RE = read; never both high.
  - The timeout counter starts at 0 on entry and increments each cycle without GNT.
  - GNT high: capture RDATA for reads, status 0x00, go to S_STAT.
  - Counter reaches TIMEOUT-1 without GNT: status 0x01, go to S_STAT.
  - GNT in the same cycle the counter hits TIMEOUT-1: GNT wins, status 0x00.
  - On exit, REQ/CE/WE/RE deassert on the next cycle. A bus transaction therefore has REQ high ≥1 cycle, and GNT in the first REQ cycle gives 1-cycle latency.
- S_STAT: o_TX_VALID = 1 with the status byte, held stable until i_TX_READY.
  - Read with ok status: go to S_RDATA.
  - Otherwise: go to S_OP.
- S_RDATA: send 4 bytes LSB first.
  - TX_VALID stays high between bytes; each byte advances only on READY.
  - After byte 3, go to S_OP.

Invariants:
- o_RX_READY and o_TX_VALID are never high together.
- Bus outputs are 0 in every state except S_BUS.
- i_BUS_GNT outside S_BUS is ignored.
- RX_VALID low stalls the receive states indefinitely (no timeout).
- A new command cannot start until the previous response has fully drained.

Test Plan:
- Write, then read:
  - Stimulus: bytes 0x12, 00 00 00 10, EF BE AD DE; responder grants after 3 cycles.
  - Required: ADDR = 0x10000000, CE = 0x02, WDATA = 0xDEADBEEF, HB = 10, WE = 1 for exactly 3 REQ cycles, then TX 0x00.
  - Follow with read 0x22 at the same address returning 0xDEADBEEF. Required TX: 00 EF BE AD DE.
- Immediate GNT:
  - Stimulus: byte read 0x20 at 0x00000004, GNT in the first REQ cycle, RDATA = 0x000000A5.
  - Required: REQ high exactly 1 cycle; TX 00 A5 00 00 00; CE = 0x01, HB = 00.
- Timeout (TIMEOUT = 8):
  - Stimulus: no GNT.
  - Required: REQ high exactly 8 cycles, then TX 0x01 only. A following valid command succeeds.
- Errors:
  - Opcode 0x33: TX 0x02 immediately, bus untouched.
  - Opcode 0x22 at 0x90000000: all 5 bytes consumed, TX 0x03, REQ never asserted.
- Backpressure:
  - Stimulus: RX_VALID toggled randomly; TX_READY low for 5 cycles during read data.
  - Required: byte order and values are preserved; TX_DATA is stable while VALID & !READY.
- Reset mid-transaction:
  - Stimulus: assert i_RST during S_BUS with REQ high.
  - Required: all outputs are 0 asynchronously. After release, a fresh write command completes with status 0x00.
